// File: rtl/lsp_get_tdist_pkg.sv
// Shared constants for the LSP weighted-distance block: vector length, shift amount,
// default RAM buffer bases and the controller state encoding.
package lsp_get_tdist_pkg;

    localparam int M       = 10;
    localparam int SHL_AMT = 4;

    localparam logic [10:0] WEGT_BASE  = 11'h100;
    localparam logic [10:0] BUF_BASE   = 11'h110;
    localparam logic [10:0] RBUF_BASE  = 11'h120;
    localparam logic [10:0] PEFF_BASE  = 11'h130;
    localparam logic [10:0] TDIST_BASE = 11'h3F0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_RD2,
        S_SUB,
        S_MULT,
        S_LMULT,
        S_SHL,
        S_SHLW,
        S_FIN
    } state_t;

endpackage

// File: rtl/lsp_get_tdist_if.sv
// Bus bundle between lsp_get_tdist (master) and its environment (slave): control,
// RAM port and the request/response ports of the shared basic-op units.
interface lsp_get_tdist_if;

    logic        start;
    logic [10:0] wegtAddr;
    logic [10:0] bufAddr;
    logic [10:0] rbufAddr;
    logic [10:0] peffAddr;
    logic [10:0] tdistAddr;

    logic [31:0] memIn;
    logic [10:0] memReadAddr;
    logic        memWriteEn;
    logic [10:0] memWriteAddr;
    logic [31:0] memOut;

    logic [15:0] subOutA;
    logic [15:0] subOutB;
    logic [15:0] subIn;
    logic [15:0] multOutA;
    logic [15:0] multOutB;
    logic [15:0] multIn;
    logic [15:0] L_multOutA;
    logic [15:0] L_multOutB;
    logic [31:0] L_multIn;
    logic [31:0] L_shlOutVar1;
    logic [15:0] L_shlNumShiftOut;
    logic        L_shlReady;
    logic [31:0] L_shlIn;
    logic        L_shlDone;
    logic [31:0] L_macOutA;
    logic [15:0] L_macOutB;
    logic [15:0] L_macOutC;
    logic [31:0] L_macIn;

    logic [31:0] L_tdist;
    logic        done;

    modport master (
        input  start, wegtAddr, bufAddr, rbufAddr, peffAddr, tdistAddr, memIn,
        input  subIn, multIn, L_multIn, L_shlIn, L_shlDone, L_macIn,
        output memReadAddr, memWriteEn, memWriteAddr, memOut,
        output subOutA, subOutB, multOutA, multOutB, L_multOutA, L_multOutB,
        output L_shlOutVar1, L_shlNumShiftOut, L_shlReady,
        output L_macOutA, L_macOutB, L_macOutC, L_tdist, done
    );

    modport slave (
        output start, wegtAddr, bufAddr, rbufAddr, peffAddr, tdistAddr, memIn,
        output subIn, multIn, L_multIn, L_shlIn, L_shlDone, L_macIn,
        input  memReadAddr, memWriteEn, memWriteAddr, memOut,
        input  subOutA, subOutB, multOutA, multOutB, L_multOutA, L_multOutB,
        input  L_shlOutVar1, L_shlNumShiftOut, L_shlReady,
        input  L_macOutA, L_macOutB, L_macOutC, L_tdist, done
    );

endinterface

// File: rtl/lsp_get_tdist.sv
// G.729 weighted LSP distance L_tdist over M words using the shared basic-op units.
// Optional macro LSP_TDIST_WRITE_EN also writes the result to RAM at tdistAddr with done.
module lsp_get_tdist
    import lsp_get_tdist_pkg::*;
(
    input logic            clk,
    input logic            reset,
    lsp_get_tdist_if.master bus
);

    state_t      r_state;
    logic [3:0]  r_j;
    logic [15:0] r_buf;
    logic [15:0] r_tmp;
    logic [31:0] r_prod;
    logic [31:0] r_acc;
    logic [31:0] r_tdist;
    logic        w_unused;

    // Operand and address decode: every output idles at 0 outside the state that uses it.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        bus.memReadAddr      = '0;
        bus.memWriteEn       = 1'b0;
        bus.memWriteAddr     = '0;
        bus.memOut           = '0;
        bus.subOutA          = '0;
        bus.subOutB          = '0;
        bus.multOutA         = '0;
        bus.multOutB         = '0;
        bus.L_multOutA       = '0;
        bus.L_multOutB       = '0;
        bus.L_shlOutVar1     = '0;
        bus.L_shlNumShiftOut = '0;
        bus.L_shlReady       = 1'b0;
        bus.L_macOutA        = '0;
        bus.L_macOutB        = '0;
        bus.L_macOutC        = '0;
        bus.done             = 1'b0;
        case (r_state)
            S_RD:  bus.memReadAddr = {bus.bufAddr[10:4], r_j};
            S_RD2: bus.memReadAddr = {bus.rbufAddr[10:4], r_j};
            S_SUB: begin
                bus.subOutA     = r_buf;
                bus.subOutB     = bus.memIn[15:0];
                bus.memReadAddr = {bus.peffAddr[10:4], r_j};
            end
            S_MULT: begin
                bus.multOutA    = r_tmp;
                bus.multOutB    = bus.memIn[15:0];
                bus.memReadAddr = {bus.wegtAddr[10:4], r_j};
            end
            S_LMULT: begin
                bus.L_multOutA = bus.memIn[15:0];
                bus.L_multOutB = r_tmp;
            end
            S_SHL: begin
                bus.L_shlReady       = 1'b1;
                bus.L_shlOutVar1     = r_prod;
                bus.L_shlNumShiftOut = 16'(SHL_AMT);
            end
            S_SHLW: begin
                // Shift operands stay on the bus until the unit reports done.
                bus.L_shlOutVar1     = r_prod;
                bus.L_shlNumShiftOut = 16'(SHL_AMT);
                bus.L_macOutA        = r_acc;
                bus.L_macOutB        = bus.L_shlIn[31:16];
                bus.L_macOutC        = r_tmp;
            end
            S_FIN: begin
                bus.done = 1'b1;
`ifdef LSP_TDIST_WRITE_EN
                bus.memWriteEn   = 1'b1;
                bus.memWriteAddr = bus.tdistAddr;
                bus.memOut       = r_acc;
`endif
            end
            default: ;
        endcase
    end

    assign bus.L_tdist = r_tdist;

    // NOTE: state is asynchronously cleared and updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_buf   <= '0;
            r_tmp   <= '0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_tdist <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_acc   <= '0;
                    r_j     <= '0;
                    r_state <= S_RD;
                end
                S_RD:  r_state <= S_RD2;
                S_RD2: begin
                    r_buf   <= bus.memIn[15:0];
                    r_state <= S_SUB;
                end
                S_SUB: begin
                    r_tmp   <= bus.subIn;
                    r_state <= S_MULT;
                end
                S_MULT: begin
                    r_tmp   <= bus.multIn;
                    r_state <= S_LMULT;
                end
                S_LMULT: begin
                    r_prod  <= bus.L_multIn;
                    r_state <= S_SHL;
                end
                S_SHL: r_state <= S_SHLW;
                S_SHLW: if (bus.L_shlDone) begin
                    r_acc <= bus.L_macIn;
                    if (r_j == 4'(M - 1)) begin
                        r_state <= S_FIN;
                    end else begin
                        r_j     <= r_j + 4'd1;
                        r_state <= S_RD;
                    end
                end
                S_FIN: begin
                    r_tdist <= r_acc;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bits of the bus this block deliberately ignores.
`ifdef LSP_TDIST_WRITE_EN
    assign w_unused = ^{bus.memIn[31:16], bus.L_shlIn[15:0], bus.wegtAddr[3:0],
                        bus.bufAddr[3:0], bus.rbufAddr[3:0], bus.peffAddr[3:0]};
`else
    assign w_unused = ^{bus.memIn[31:16], bus.L_shlIn[15:0], bus.wegtAddr[3:0],
                        bus.bufAddr[3:0], bus.rbufAddr[3:0], bus.peffAddr[3:0],
                        bus.tdistAddr};
`endif

endmodule

// File: tb/tb_lsp_get_tdist.sv
// Self-checking bench for lsp_get_tdist: RAM and basic-op unit models, directed
// cases plus randomized vectors compared against an ITU arithmetic reference.
module tb_lsp_get_tdist;
    import lsp_get_tdist_pkg::*;

    logic clk;
    logic reset;
    lsp_get_tdist_if bus ();

    lsp_get_tdist dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ITU-T basic operators (saturating)
    function automatic logic [15:0] sat16(input longint v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        return 32'(v);
    endfunction

    function automatic logic [15:0] f_sub(input logic [15:0] a, input logic [15:0] b);
        longint la, lb;
        la = $signed(a);
        lb = $signed(b);
        return sat16(la - lb);
    endfunction

    function automatic logic [15:0] f_mult(input logic [15:0] a, input logic [15:0] b);
        longint la, lb;
        la = $signed(a);
        lb = $signed(b);
        return sat16((la * lb) >>> 15);
    endfunction

    function automatic logic [31:0] f_lmult(input logic [15:0] a, input logic [15:0] b);
        longint la, lb;
        la = $signed(a);
        lb = $signed(b);
        return sat32(la * lb * 2);
    endfunction

    function automatic logic [31:0] f_ladd(input logic [31:0] a, input logic [31:0] b);
        longint la, lb;
        la = $signed(a);
        lb = $signed(b);
        return sat32(la + lb);
    endfunction

    function automatic logic [31:0] f_lshl(input logic [31:0] x, input logic [15:0] n);
        longint v;
        int     sh;
        v  = $signed(x);
        sh = $signed(n);
        if (sh < 0) return 32'(v >>> ((-sh > 31) ? 31 : -sh));
        for (int i = 0; i < sh; i++) begin
            if (v > 64'sh3FFFFFFF) return 32'h7FFFFFFF;
            if (v < -64'sh40000000) return 32'h80000000;
            v = v * 2;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] f_lmac(input logic [31:0] acc, input logic [15:0] a,
                                           input logic [15:0] b);
        return f_ladd(acc, f_lmult(a, b));
    endfunction

    // Shared operator units
    assign bus.subIn    = f_sub(bus.subOutA, bus.subOutB);
    assign bus.multIn   = f_mult(bus.multOutA, bus.multOutB);
    assign bus.L_multIn = f_lmult(bus.L_multOutA, bus.L_multOutB);
    assign bus.L_shlIn  = f_lshl(bus.L_shlOutVar1, bus.L_shlNumShiftOut);
    assign bus.L_macIn  = f_lmac(bus.L_macOutA, bus.L_macOutB, bus.L_macOutC);

    // L_shl unit with programmable latency: done arrives shl_lat cycles after the request
    int shl_lat = 1;
    int shl_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) shl_cnt <= 0;
        else if (bus.L_shlReady) shl_cnt <= shl_lat;
        else if (shl_cnt != 0) shl_cnt <= shl_cnt - 1;
    end
    assign bus.L_shlDone = (shl_cnt == 1);

    // RAM: one-cycle read latency; DUT writes are captured separately
    logic [31:0] mem [0:2047];
    always @(posedge clk) bus.memIn <= mem[bus.memReadAddr];

    int          wr_cnt = 0;
    int          wr_without_done = 0;
    int          done_cnt = 0;
    logic [10:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    always @(posedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.memWriteEn) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.memWriteAddr;
            wr_data <= bus.memOut;
            if (!bus.done) wr_without_done <= wr_without_done + 1;
        end
    end

    // Reference data and model
    logic [15:0] wegtv [M];
    logic [15:0] bufv  [M];
    logic [15:0] rbufv [M];
    logic [15:0] peffv [M];
    logic [31:0] last_tdist = '0;
    int          n_runs = 0;

    function automatic logic [31:0] ref_tdist();
        logic [31:0] acc, sh;
        logic [15:0] t, hi;
        acc = '0;
        for (int j = 0; j < M; j++) begin
            t   = f_mult(f_sub(bufv[j], rbufv[j]), peffv[j]);
            sh  = f_lshl(f_lmult(wegtv[j], t), 16'(SHL_AMT));
            hi  = sh[31:16];
            acc = f_lmac(acc, hi, t);
        end
        return acc;
    endfunction

    task automatic load_mem();
        logic [31:0] r;
        for (int j = 0; j < M; j++) begin
            r = $urandom; mem[{bus.wegtAddr[10:4], 4'(j)}] = {r[31:16], wegtv[j]};
            r = $urandom; mem[{bus.bufAddr[10:4],  4'(j)}] = {r[31:16], bufv[j]};
            r = $urandom; mem[{bus.rbufAddr[10:4], 4'(j)}] = {r[31:16], rbufv[j]};
            r = $urandom; mem[{bus.peffAddr[10:4], 4'(j)}] = {r[31:16], peffv[j]};
        end
    endtask

    task automatic set_uniform(input logic [15:0] w, input logic [15:0] b,
                               input logic [15:0] rb, input logic [15:0] p);
        for (int j = 0; j < M; j++) begin
            wegtv[j] = w; bufv[j] = b; rbufv[j] = rb; peffv[j] = p;
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        if (r[31]) return r[15:0];
        return 16'($signed(r[11:0]));
    endfunction

    // One start pulse; checks latency, the held result mid-run, the new result and a single done
    task automatic run(input string tag, input logic [31:0] exp, input int exp_cycles);
        int cnt;
        int d0;
        d0 = done_cnt;
        bus.start = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) bus.start = 1'b0;
            if (cnt == 35) check({tag, "_held"}, bus.L_tdist, last_tdist);
        end while (!bus.done && cnt < 2000);
        check({tag, "_latency"}, 32'(cnt), 32'(exp_cycles));
        @(posedge clk); #1;
        check({tag, "_tdist"}, bus.L_tdist, exp);
        check({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        last_tdist = exp;
        n_runs++;
    endtask

    logic [31:0] exp1, exp2;
    int          gap, d0;
    logic [31:0] r;

    initial begin
        bus.start     = 1'b0;
        bus.wegtAddr  = WEGT_BASE;
        bus.bufAddr   = BUF_BASE;
        bus.rbufAddr  = RBUF_BASE;
        bus.peffAddr  = PEFF_BASE;
        bus.tdistAddr = TDIST_BASE;
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tdist", bus.L_tdist, 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_shl_ready", 32'(bus.L_shlReady), 32'd0);
        check("rst_rd_addr", 32'(bus.memReadAddr), 32'd0);
        check("rst_wr_en", 32'(bus.memWriteEn), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Test 1: buf == rbuf
        for (int j = 0; j < M; j++) begin
            r = $urandom;
            wegtv[j] = 16'd2048; bufv[j] = r[15:0]; rbufv[j] = r[15:0]; peffv[j] = 16'd32767;
        end
        load_mem();
        run("t1", 32'd0, 7 * M + 1);

        // Test 2: only word 0 contributes
        set_uniform(16'd0, 16'd0, 16'd0, 16'd0);
        wegtv[0] = 16'd2048; bufv[0] = 16'd1000; peffv[0] = 16'd32767;
        load_mem();
        check("t2_model", ref_tdist(), 32'd1996002);
        run("t2", 32'd1996002, 7 * M + 1);
`ifdef LSP_TDIST_WRITE_EN
        check("t6_wr_addr", 32'(wr_addr), 32'h3F0);
        check("t6_wr_data", wr_data, 32'd1996002);
`endif

        // Test 3: shift and accumulator saturation
        set_uniform(16'd32767, 16'd32767, 16'd0, 16'd32767);
        load_mem();
        run("t3", 32'h7FFFFFFF, 7 * M + 1);

        // Test 4: reset while waiting on a slow L_shl
        set_uniform(16'd0, 16'd0, 16'd0, 16'd0);
        wegtv[0] = 16'd2048; bufv[0] = 16'd1000; peffv[0] = 16'd32767;
        load_mem();
        shl_lat = 20;
        bus.start = 1'b1;
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
            bus.start = 1'b0;
        end while (!bus.L_shlReady && gap < 200);
        check("t4_reached_shl", 32'(bus.L_shlReady), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("t4_rst_tdist", bus.L_tdist, 32'd0);
        check("t4_rst_var1", bus.L_shlOutVar1, 32'd0);
        check("t4_rst_mac_c", 32'(bus.L_macOutC), 32'd0);
        check("t4_rst_done", 32'(bus.done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        shl_lat = 1;
        last_tdist = 32'd0;
        run("t4_rerun", 32'd1996002, 7 * M + 1);

        // Test 5: start held across two runs; buf changes between them
        for (int j = 0; j < M; j++) begin
            wegtv[j] = rand_word(); bufv[j] = rand_word(); rbufv[j] = rand_word(); peffv[j] = rand_word();
        end
        load_mem();
        exp1 = ref_tdist();
        bus.start = 1'b1;
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (!bus.done && gap < 2000);
        check("t5_first_latency", 32'(gap), 32'(7 * M + 1));
        for (int j = 0; j < M; j++) bufv[j] = rand_word();
        load_mem();
        exp2 = ref_tdist();
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
            if (gap == 1) check("t5_first_tdist", bus.L_tdist, exp1);
            if (gap == 2) bus.start = 1'b0;
            if (gap == 40) check("t5_held", bus.L_tdist, exp1);
        end while (!bus.done && gap < 2000);
        // One IDLE cycle samples the held start, then a full 71-cycle run.
        check("t5_restart_gap", 32'(gap), 32'(7 * M + 2));
        @(posedge clk); #1;
        check("t5_second_tdist", bus.L_tdist, exp2);
        last_tdist = exp2;
        n_runs += 2;

        // Randomized runs: data, L_shl latency and the ignored low base bits
        for (int k = 0; k < 8; k++) begin
            r = $urandom;
            bus.wegtAddr = {WEGT_BASE[10:4], r[3:0]};
            bus.bufAddr  = {BUF_BASE[10:4],  r[7:4]};
            bus.rbufAddr = {RBUF_BASE[10:4], r[11:8]};
            bus.peffAddr = {PEFF_BASE[10:4], r[15:12]};
            shl_lat = $urandom_range(1, 4);
            for (int j = 0; j < M; j++) begin
                wegtv[j] = rand_word(); bufv[j] = rand_word(); rbufv[j] = rand_word(); peffv[j] = rand_word();
            end
            load_mem();
            run($sformatf("rnd%0d", k), ref_tdist(), M * (6 + shl_lat) + 1);
        end

        check("done_total", 32'(done_cnt), 32'(n_runs));
        check("wr_outside_done", 32'(wr_without_done), 32'd0);
`ifdef LSP_TDIST_WRITE_EN
        check("wr_total", 32'(wr_cnt), 32'(n_runs));
        check("wr_last_addr", 32'(wr_addr), 32'h3F0);
        check("wr_last_data", wr_data, last_tdist);
`else
        check("wr_never", 32'(wr_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
